seg7_scan_ctrl: RTL

- Parametrised time-multiplexed driver for a common-anode 7-segment display bank; next generation of the fixed 7-digit scanner.
- Adds:
  - configurable digit count and refresh rate;
  - full hex decode (0-F);
  - per-digit enable and decimal point;
  - leading-zero blanking;
  - PWM brightness;
  - tear-free frame-synchronous loading of display data.
- Sits between counter/datapath logic and the board's an/seg/dp pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan controller.
//   HEX_SEG_TABLE : active-low {g,f,e,d,c,b,a} pattern for every hex nibble.
//   SEG_BLANK     : all segments off.
//   AN_OFF        : all anodes off. This is sized for the largest bank (8 digits);
//                   users slice it down to their own digit count.
//   hex_to_seg    : table lookup used by the decoder.
package seg7_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [MAX_DIGITS-1:0] AN_OFF = 8'hFF;

   // Entry 15 is listed first so that HEX_SEG_TABLE[n] is the pattern for nibble n.
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: purely combinational nibble -> active-low segment pattern.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  {g,f,e,d,c,b,a}, active-low; every code is defined
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for a common-anode 7-segment bank.
// Each digit owns a slot of SLOT_CYCLES clocks. Inside its slot, the digit's anode
// is pulsed for a brightness-dependent fraction of the slot. Display data is loaded
// into a pending buffer and promoted to the shadow (displayed) copy only at the
// frame boundary, so a frame never shows mixed data.
// Ports:
//   CLK100MHZ   in   system clock
//   reset       in   asynchronous active-high reset
//   load        in   one-cycle strobe capturing digits_in/dp_in/en_in
//   digits_in   in   nibble i drives digit i (digit N_DIGITS-1 is the most significant)
//   dp_in       in   decimal point request per digit (1 = lit)
//   en_in       in   digit enable (0 = dark)
//   lzb_en      in   leading-zero blanking, sampled live
//   bright      in   brightness level, sampled live
//   an          out  anode selects, active-low
//   seg         out  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
//   frame_tick  out  one-cycle pulse in the first cycle of digit 0
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = 8,
   parameter int SLOT_CYCLES = 2048,
   parameter int BRIGHT_W    = 3
) (
   input  logic                  CLK100MHZ,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   en_in,
   input  logic                  lzb_en,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
   // One brightness step, in clocks. The extra bit holds a threshold equal to SLOT_CYCLES.
   localparam logic [CNT_W:0]      STEP       = (CNT_W+1)'(SLOT_CYCLES >> BRIGHT_W);
   localparam logic [N_DIGITS-1:0] AN_ALL_OFF = AN_OFF[N_DIGITS-1:0];

   logic [CNT_W-1:0]              slot_cnt_r;
   logic [IDX_W-1:0]              idx_r;

   logic [N_DIGITS-1:0][3:0]      pend_dig_r;
   logic [N_DIGITS-1:0]           pend_dp_r;
   logic [N_DIGITS-1:0]           pend_en_r;
   logic                          pend_valid_r;

   logic [N_DIGITS-1:0][3:0]      shadow_dig_r;
   logic [N_DIGITS-1:0]           shadow_dp_r;
   // The enable mask is stored inverted, so a cleared shadow shows "0" on every digit
   // instead of going dark.
   logic [N_DIGITS-1:0]           shadow_off_r;

   logic [N_DIGITS-1:0]           an_r;
   logic [6:0]                    seg_r;
   logic                          dp_r;
   logic                          frame_tick_r;

   logic                          boundary_s;
   logic [3:0]                    cur_nib_s;
   logic [6:0]                    dec_seg_s;
   logic [N_DIGITS-1:0]           blank_s;
   logic [CNT_W:0]                thr_s;
   logic [N_DIGITS-1:0]           an_nxt_s;
   logic [6:0]                    seg_nxt_s;
   logic                          dp_nxt_s;

   assign boundary_s = (slot_cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
   assign cur_nib_s  = shadow_dig_r[idx_r];

   seg7_hex_decode u_hex_decode (
      .nibble (cur_nib_s),
      .seg    (dec_seg_s)
   );

   // Blanking mask: digit k is blanked while every enabled nibble from the top down to k is zero.
   always_comb begin : blank_mask
      logic zero_run_v;
      zero_run_v = 1'b1;
      blank_s    = {N_DIGITS{1'b0}};
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_run_v = zero_run_v & (shadow_off_r[k] | (shadow_dig_r[k] == 4'h0));
         blank_s[k] = zero_run_v;
      end
   end

   // Next an/seg/dp for the digit and slot position currently selected.
   always_comb begin
      thr_s     = ((CNT_W+1)'(bright) + (CNT_W+1)'(1)) * STEP;
      an_nxt_s  = AN_ALL_OFF;
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
      if (!shadow_off_r[idx_r]) begin
         if (lzb_en && blank_s[idx_r]) begin
            seg_nxt_s = SEG_BLANK;
         end else begin
            seg_nxt_s = dec_seg_s;
         end
         dp_nxt_s = ~shadow_dp_r[idx_r];
         // The last clock of every slot is dark, so the anodes of adjacent digits never overlap.
         if (({1'b0, slot_cnt_r} < thr_s) && (slot_cnt_r != CNT_LAST)) begin
            an_nxt_s[idx_r] = 1'b0;
         end else begin
            an_nxt_s = AN_ALL_OFF;
         end
      end else begin
         an_nxt_s  = AN_ALL_OFF;
         seg_nxt_s = SEG_BLANK;
         dp_nxt_s  = 1'b1;
      end
   end

   // Slot counter and digit index.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         slot_cnt_r <= {CNT_W{1'b0}};
         idx_r      <= {IDX_W{1'b0}};
      end else if (slot_cnt_r == CNT_LAST) begin
         slot_cnt_r <= {CNT_W{1'b0}};
         if (idx_r == IDX_LAST) begin
            idx_r <= {IDX_W{1'b0}};
         end else begin
            idx_r <= idx_r + 1'b1;
         end
      end else begin
         slot_cnt_r <= slot_cnt_r + 1'b1;
      end
   end

   // Pending/shadow double buffer. A load in the boundary cycle goes straight to the shadow.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         pend_dig_r   <= {(4*N_DIGITS){1'b0}};
         pend_dp_r    <= {N_DIGITS{1'b0}};
         pend_en_r    <= {N_DIGITS{1'b0}};
         pend_valid_r <= 1'b0;
         shadow_dig_r <= {(4*N_DIGITS){1'b0}};
         shadow_dp_r  <= {N_DIGITS{1'b0}};
         shadow_off_r <= {N_DIGITS{1'b0}};
      end else if (boundary_s) begin
         pend_valid_r <= 1'b0;
         if (load) begin
            shadow_dig_r <= digits_in;
            shadow_dp_r  <= dp_in;
            shadow_off_r <= ~en_in;
         end else if (pend_valid_r) begin
            shadow_dig_r <= pend_dig_r;
            shadow_dp_r  <= pend_dp_r;
            shadow_off_r <= ~pend_en_r;
         end else begin
            shadow_dig_r <= shadow_dig_r;
         end
      end else if (load) begin
         pend_dig_r   <= digits_in;
         pend_dp_r    <= dp_in;
         pend_en_r    <= en_in;
         pend_valid_r <= 1'b1;
      end else begin
         pend_valid_r <= pend_valid_r;
      end
   end

   // Registered pin drivers and frame pulse.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         an_r         <= AN_ALL_OFF;
         seg_r        <= SEG_BLANK;
         dp_r         <= 1'b1;
         frame_tick_r <= 1'b0;
      end else begin
         an_r         <= an_nxt_s;
         seg_r        <= seg_nxt_s;
         dp_r         <= dp_nxt_s;
         frame_tick_r <= boundary_s;
      end
   end

   assign an         = an_r;
   assign seg        = seg_r;
   assign dp         = dp_r;
   assign frame_tick = frame_tick_r;

endmodule
